// File: rtl/sonar_pkg.sv
// Shared state encoding and default constants for the sonar beam sweep scheduler.
package sonar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        LISTEN,
        REPORT
    } sweep_state_e;

    localparam int DEF_ANGLE_WIDTH   = 8;
    localparam int DEF_RANGE_WIDTH   = 16;
    localparam int DEF_ANGLE_MIN     = -30;
    localparam int DEF_ANGLE_MAX     = 30;
    localparam int DEF_ANGLE_STEP    = 10;
    localparam int DEF_BURST_CYCLES  = 524288;
    localparam int DEF_LISTEN_CYCLES = 16252928;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/beam_sweep_scheduler_if.sv
// Control and result bundle between the beam sweep scheduler and its host/datapath.
interface beam_sweep_scheduler_if #(
    parameter int ANGLE_WIDTH = sonar_pkg::DEF_ANGLE_WIDTH,
    parameter int RANGE_WIDTH = sonar_pkg::DEF_RANGE_WIDTH
);
    logic                          enable_in;
    logic                          tof_valid_in;
    logic        [RANGE_WIDTH-1:0] range_in;
    logic signed [ANGLE_WIDTH-1:0] beam_angle_out;
    logic                          burst_start_out;
    logic                          active_pulse_out;
    logic                          result_valid_out;
    logic signed [ANGLE_WIDTH-1:0] result_angle_out;
    logic        [RANGE_WIDTH-1:0] result_range_out;
    logic                          result_hit_out;
    logic                          sweep_done_out;

    modport slave (
        input  enable_in, tof_valid_in, range_in,
        output beam_angle_out, burst_start_out, active_pulse_out, result_valid_out,
               result_angle_out, result_range_out, result_hit_out, sweep_done_out
    );

    modport master (
        output enable_in, tof_valid_in, range_in,
        input  beam_angle_out, burst_start_out, active_pulse_out, result_valid_out,
               result_angle_out, result_range_out, result_hit_out, sweep_done_out
    );
endinterface

// File: rtl/dwell_timer.sv
// Loadable down-counter; done_out is high whenever the count has reached zero.
module dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_value_in,
    output logic             done_out
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_in) begin
            count_d = load_value_in;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) count_q <= '0;
        else        count_q <= count_d;
    end

    assign done_out = (count_q == '0);
endmodule

// File: rtl/beam_sweep_scheduler.sv
// Sonar dwell sequencer: burst, listen, report per steering angle, sweeping the angle range.
// Define BEAM_SWEEP_PINGPONG_EN for a back-and-forth sweep instead of wrap-around.
module beam_sweep_scheduler
    import sonar_pkg::*;
#(
    parameter int ANGLE_WIDTH   = DEF_ANGLE_WIDTH,
    parameter int ANGLE_MIN     = DEF_ANGLE_MIN,
    parameter int ANGLE_MAX     = DEF_ANGLE_MAX,
    parameter int ANGLE_STEP    = DEF_ANGLE_STEP,
    parameter int BURST_CYCLES  = DEF_BURST_CYCLES,
    parameter int LISTEN_CYCLES = DEF_LISTEN_CYCLES,
    parameter int RANGE_WIDTH   = DEF_RANGE_WIDTH
) (
    input logic                  clk_in,
    input logic                  rst_in,
    beam_sweep_scheduler_if.slave bus
);
    localparam int TIMER_W = $clog2(max_int(BURST_CYCLES, LISTEN_CYCLES) + 1);
    localparam logic signed [ANGLE_WIDTH-1:0] A_MIN  = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH-1:0] A_STEP = ANGLE_WIDTH'(ANGLE_STEP);

    sweep_state_e                  state_q, state_d;
    logic signed [ANGLE_WIDTH-1:0] beam_angle_q, beam_angle_d;
    logic signed [ANGLE_WIDTH-1:0] result_angle_q, result_angle_d;
    logic        [RANGE_WIDTH-1:0] result_range_q, result_range_d;
    logic        [RANGE_WIDTH-1:0] range_q, range_d;
    logic burst_start_q, burst_start_d, active_q, active_d;
    logic result_valid_q, result_valid_d, result_hit_q, result_hit_d;
    logic sweep_done_q, sweep_done_d, hit_q, hit_d;
    logic               timer_load, timer_done, start_burst, up_now, at_end;
    logic [TIMER_W-1:0] timer_value;

`ifdef BEAM_SWEEP_PINGPONG_EN
    logic dir_up_q, dir_up_d;
    assign up_now = dir_up_q;
`else
    assign up_now = 1'b1;
`endif
    // Compared in int so a step that overshoots the limit still turns around.
    assign at_end = up_now ? (int'(beam_angle_q) + ANGLE_STEP > ANGLE_MAX)
                           : (int'(beam_angle_q) - ANGLE_STEP < ANGLE_MIN);

    dwell_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .load_in       (timer_load),
        .load_value_in (timer_value),
        .done_out      (timer_done)
    );

    always_comb begin
        state_d        = state_q;
        beam_angle_d   = beam_angle_q;
        burst_start_d  = 1'b0;
        active_d       = active_q;
        result_valid_d = 1'b0;
        result_angle_d = result_angle_q;
        result_range_d = result_range_q;
        result_hit_d   = result_hit_q;
        sweep_done_d   = 1'b0;
        hit_d          = hit_q;
        range_d        = range_q;
        timer_load     = 1'b0;
        timer_value    = '0;
        start_burst    = 1'b0;
`ifdef BEAM_SWEEP_PINGPONG_EN
        dir_up_d       = dir_up_q;
`endif
        if (state_q == LISTEN && bus.tof_valid_in && !hit_q) begin
            hit_d   = 1'b1;
            range_d = bus.range_in;
        end
        case (state_q)
            IDLE: start_burst = bus.enable_in;
            BURST: begin
                // Timer holds BURST_CYCLES in the entry cycle, so the window spans the next BURST_CYCLES cycles.
                if (burst_start_q) active_d = 1'b1;
                if (timer_done) begin
                    active_d    = 1'b0;
                    state_d     = LISTEN;
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(LISTEN_CYCLES - 1);
                end
            end
            LISTEN: begin
                if (timer_done) begin
                    state_d        = REPORT;
                    result_valid_d = 1'b1;
                    result_angle_d = beam_angle_q;
                    result_range_d = range_d;
                    result_hit_d   = hit_d;
                    sweep_done_d   = at_end;
                end
            end
            REPORT: begin
`ifdef BEAM_SWEEP_PINGPONG_EN
                if (at_end) dir_up_d = !dir_up_q;
                beam_angle_d = (up_now ^ at_end) ? beam_angle_q + A_STEP : beam_angle_q - A_STEP;
`else
                beam_angle_d = at_end ? A_MIN : beam_angle_q + A_STEP;
`endif
                state_d     = IDLE;
                start_burst = bus.enable_in;
            end
            default: state_d = IDLE;
        endcase
        if (start_burst) begin
            state_d       = BURST;
            burst_start_d = 1'b1;
            hit_d         = 1'b0;
            range_d       = '0;
            timer_load    = 1'b1;
            timer_value   = TIMER_W'(BURST_CYCLES);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            beam_angle_q   <= A_MIN;
            burst_start_q  <= 1'b0;
            active_q       <= 1'b0;
            result_valid_q <= 1'b0;
            result_angle_q <= '0;
            result_range_q <= '0;
            result_hit_q   <= 1'b0;
            sweep_done_q   <= 1'b0;
            hit_q          <= 1'b0;
            range_q        <= '0;
`ifdef BEAM_SWEEP_PINGPONG_EN
            dir_up_q       <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            beam_angle_q   <= beam_angle_d;
            burst_start_q  <= burst_start_d;
            active_q       <= active_d;
            result_valid_q <= result_valid_d;
            result_angle_q <= result_angle_d;
            result_range_q <= result_range_d;
            result_hit_q   <= result_hit_d;
            sweep_done_q   <= sweep_done_d;
            hit_q          <= hit_d;
            range_q        <= range_d;
`ifdef BEAM_SWEEP_PINGPONG_EN
            dir_up_q       <= dir_up_d;
`endif
        end
    end

    assign bus.beam_angle_out   = beam_angle_q;
    assign bus.burst_start_out  = burst_start_q;
    assign bus.active_pulse_out = active_q;
    assign bus.result_valid_out = result_valid_q;
    assign bus.result_angle_out = result_angle_q;
    assign bus.result_range_out = result_range_q;
    assign bus.result_hit_out   = result_hit_q;
    assign bus.sweep_done_out   = sweep_done_q;
endmodule
